// File: rtl/bpred_gshare_pkg.sv
// Shared definitions for the gshare predictor and the stages that talk to it.
// FE_STAGE and AGEX_STAGE pack and unpack the update bundle with the same layout.
package bpred_gshare_pkg;

  // 2-bit saturating counter encodings
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // Every PHT counter starts out weakly not-taken
  localparam logic [1:0] PHT_RESET = WNT;

  // Default geometry, used by the packed update bundle below
  localparam int DEF_DBITS        = 32;
  localparam int DEF_GHR_BITS     = 8;
  localparam int DEF_BTB_IDX_BITS = 6;

  // BTB tag covers the PC bits above the index and the byte offset
  function automatic int btbTagBits(input int dbits, input int idxBits);
    return dbits - idxBits - 2;
  endfunction

  // Width of the from_AGEX update bundle: valid, pc, pht_idx, taken, target, mispred
  function automatic int updBundleBits(input int dbits, input int ghrBits);
    return 1 + dbits + ghrBits + 1 + dbits + 1;
  endfunction

  // from_AGEX update bundle at the default geometry
  typedef struct packed {
    logic                        valid;
    logic [DEF_DBITS-1:0]        pc;
    logic [DEF_GHR_BITS-1:0]     pht_idx;
    logic                        taken;
    logic [DEF_DBITS-1:0]        target;
    logic                        mispred;
  } agex_upd_t;

  localparam int UPD_BUNDLE_BITS = updBundleBits(DEF_DBITS, DEF_GHR_BITS);

endpackage

// File: rtl/bpred_gshare_sat_counter2.sv
// Next-state logic for a 2-bit saturating up/down counter.
module sat_counter2
  import bpred_gshare_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       up_i,
  output logic [1:0] ctr_o
);

  // Step toward strongly-taken or strongly-not-taken, holding at either end
  always_comb begin
    ctr_o = ctr_i;
    if (up_i) begin
      if (ctr_i != ST) ctr_o = ctr_i + 2'b01;
    end else begin
      if (ctr_i != SNT) ctr_o = ctr_i - 2'b01;
    end
  end

endmodule

// File: rtl/bpred_gshare.sv
// Gshare branch predictor: GHR-xor-PC indexed PHT of 2-bit counters plus a
// direct-mapped BTB. Lookups are combinational from state; updates arrive from
// AGEX on resolution and commit at the clock edge with no bypass to lookups.
module bpred_gshare
  import bpred_gshare_pkg::*;
#(
  parameter int DBITS        = 32,
  parameter int GHR_BITS     = 8,
  parameter int BTB_IDX_BITS = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DBITS-1:0]    lkp_pc,
  output logic                lkp_taken,
  output logic [DBITS-1:0]    lkp_target,
  output logic [GHR_BITS-1:0] lkp_pht_idx,
  input  logic                upd_valid,
  input  logic [DBITS-1:0]    upd_pc,
  input  logic [GHR_BITS-1:0] upd_pht_idx,
  input  logic                upd_taken,
  input  logic [DBITS-1:0]    upd_target,
  input  logic                upd_mispred,
  output logic [GHR_BITS-1:0] ghr_out,
  output logic [DBITS-1:0]    stat_branches,
  output logic [DBITS-1:0]    stat_mispreds
);

  localparam int PHT_ENTRIES = 1 << GHR_BITS;
  localparam int BTB_ENTRIES = 1 << BTB_IDX_BITS;
  localparam int TAG_BITS    = btbTagBits(DBITS, BTB_IDX_BITS);

  logic [GHR_BITS-1:0]     ghr_q, ghr_d;
  logic [DBITS-1:0]        branches_q, branches_d;
  logic [DBITS-1:0]        mispreds_q, mispreds_d;
  logic [1:0]              pht_q [PHT_ENTRIES];
  logic [BTB_ENTRIES-1:0]  btb_valid_q;
  logic [TAG_BITS-1:0]     btb_tag_q [BTB_ENTRIES];
  logic [DBITS-1:0]        btb_tgt_q [BTB_ENTRIES];

  logic [BTB_IDX_BITS-1:0] lkp_btb_idx;
  logic [TAG_BITS-1:0]     lkp_tag;
  logic                    lkp_btb_hit;
  logic [1:0]              lkp_ctr;

  logic [BTB_IDX_BITS-1:0] upd_btb_idx;
  logic [TAG_BITS-1:0]     upd_tag;
  logic [1:0]              upd_ctr_cur;
  logic [1:0]              upd_ctr_next;

  // The byte offset of the resolved PC plays no part in indexing or tagging
  logic                    unused_upd_pc_bits;
  assign unused_upd_pc_bits = ^upd_pc[1:0];

  // Lookup path: hash PC with history, probe BTB, pick taken target or fall-through
  always_comb begin
    lkp_pht_idx = lkp_pc[GHR_BITS+1:2] ^ ghr_q;
    lkp_btb_idx = lkp_pc[BTB_IDX_BITS+1:2];
    lkp_tag     = lkp_pc[DBITS-1:BTB_IDX_BITS+2];
    lkp_btb_hit = btb_valid_q[lkp_btb_idx] && (btb_tag_q[lkp_btb_idx] == lkp_tag);
    lkp_ctr     = pht_q[lkp_pht_idx];
    lkp_taken   = lkp_btb_hit && lkp_ctr[1];
    lkp_target  = lkp_taken ? btb_tgt_q[lkp_btb_idx] : lkp_pc + DBITS'(4);
  end

  // Update path: counter step for the indexed PHT entry, history shift, stats
  always_comb begin
    upd_btb_idx = upd_pc[BTB_IDX_BITS+1:2];
    upd_tag     = upd_pc[DBITS-1:BTB_IDX_BITS+2];
    upd_ctr_cur = pht_q[upd_pht_idx];
    ghr_d       = ghr_q;
    branches_d  = branches_q;
    mispreds_d  = mispreds_q;
    if (upd_valid) begin
      ghr_d      = {ghr_q[GHR_BITS-2:0], upd_taken};
      branches_d = branches_q + DBITS'(1);
      mispreds_d = mispreds_q + DBITS'(upd_mispred);
    end
  end

  sat_counter2 u_ctr (
    .ctr_i (upd_ctr_cur),
    .up_i  (upd_taken),
    .ctr_o (upd_ctr_next)
  );

  // Architectural state that must come out of reset in a known condition
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr_q       <= '0;
      branches_q  <= '0;
      mispreds_q  <= '0;
      btb_valid_q <= '0;
      for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= PHT_RESET;
    end else begin
      ghr_q      <= ghr_d;
      branches_q <= branches_d;
      mispreds_q <= mispreds_d;
      if (upd_valid) pht_q[upd_pht_idx] <= upd_ctr_next;
      if (upd_valid && upd_taken) btb_valid_q[upd_btb_idx] <= 1'b1;
    end
  end

  // BTB payload is qualified by the valid bits, so it needs no reset
  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken && !reset) begin
      btb_tag_q[upd_btb_idx] <= upd_tag;
      btb_tgt_q[upd_btb_idx] <= upd_target;
    end
  end

  assign ghr_out       = ghr_q;
  assign stat_branches = branches_q;
  assign stat_mispreds = mispreds_q;

endmodule

// File: doc/bpred_gshare.md
# bpred_gshare

Gshare branch predictor serving the fetch stage's per-cycle prediction lookups and consuming branch resolutions from the address-generation/execute stage. It is the responder for FE's prediction request and the receiver of AGEX's branch-history/outcome updates. It holds a global history register (GHR), a pattern history table (PHT) of 2-bit saturating counters and a direct-mapped branch target buffer (BTB). It sits beside FE_STAGE in the pipeline frame.

## Interface
Parameters:
- DBITS, 32, PC/data width
- GHR_BITS, 8, history length; PHT has 2^GHR_BITS entries
- BTB_IDX_BITS, 6, BTB has 2^BTB_IDX_BITS entries

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- lkp_pc  in  DBITS  PC being fetched this cycle
- lkp_taken  out  1  predicted taken
- lkp_target  out  DBITS  predicted next PC
- lkp_pht_idx  out  GHR_BITS  PHT index used; FE carries it down the pipe
- upd_valid  in  1  a branch resolved in AGEX this cycle
- upd_pc  in  DBITS  resolved branch PC
- upd_pht_idx  in  GHR_BITS  index returned from lookup time
- upd_taken  in  1  actual outcome
- upd_target  in  DBITS  actual taken target
- upd_mispred  in  1  AGEX detected misprediction
- ghr_out  out  GHR_BITS  current GHR
- stat_branches  out  DBITS  resolved-branch count
- stat_mispreds  out  DBITS  mispredict count

## Operation
- Lookup (combinational from state): pht_idx = lkp_pc[GHR_BITS+1:2] ^ ghr. BTB index = lkp_pc[BTB_IDX_BITS+1:2], tag = lkp_pc[DBITS-1:BTB_IDX_BITS+2]. btb_hit = valid[i] && tag match.
- lkp_taken = btb_hit && pht[pht_idx][1]. lkp_target = lkp_taken ? btb_target[i] : lkp_pc + 4 (modulo 2^DBITS).
- Update on upd_valid at posedge:
  - pht[upd_pht_idx]: taken → increment saturating at 2'b11; not taken → decrement saturating at 2'b00.
  - GHR <= {ghr[GHR_BITS-2:0], upd_taken}; history is non-speculative (resolution only).
  - If upd_taken: BTB entry at upd_pc's index is written valid with upd_pc tag and upd_target (allocate or overwrite). Not-taken never touches BTB.
  - stat_branches += 1; stat_mispreds += upd_mispred. Both wrap at 2^DBITS.
- upd_mispred without upd_valid is ignored.
- Reset: all PHT counters 2'b01 (weakly not-taken), all BTB valid bits 0, GHR 0, stats 0. Hence after reset lkp_taken=0, lkp_target=lkp_pc+4, lkp_pht_idx=lkp_pc[GHR_BITS+1:2], ghr_out=0. BTB tag/target contents need no reset.

## Timing
- Lookup latency 0 cycles: outputs depend only on lkp_pc and registered state.
- Update takes effect at the posedge sampling upd_valid; a lookup in that same cycle sees pre-update PHT, BTB and GHR (no bypass).
- Lookup and update to the same PHT entry or BTB entry in one cycle: lookup returns the old value, update commits normally.
- One update per cycle max; no backpressure, no ready signal.
- Reset asserted mid-operation clears state immediately (asynchronous); a pending update in that cycle is discarded.

## Structure
- Shared package: counter encodings (SNT=00, WNT=01, WT=10, ST=11), PHT reset value, BTB entry field widths derived from DBITS/BTB_IDX_BITS, and the from_AGEX update bundle width so AGEX_STAGE and FE_STAGE pack/unpack identically.
- Sub-module sat_counter2 (2-bit saturating up/down, combinational next-state) is natural; instantiated once on the update path.

## Test plan
- Reset: lkp_pc=0x100 → lkp_taken=0, lkp_target=0x104, lkp_pht_idx=0x40, ghr_out=0, stats 0.
- Training: two updates pc=0x100, idx=0x40, taken, target=0x200 → counter 01→10→11; ghr_out=0x03; lookup pc=0x100 (idx 0x40^0x03=0x43, untrained, 01) → not taken; a lookup hitting idx 0x40 → taken, target 0x200.
- Saturation: 5 taken updates at idx 0x10 then 1 not-taken → counter 11 then 10, still predicts taken; from reset 3 not-taken updates → stays 00.
- BTB alias: taken update pc=0x100 target 0x200, then taken update pc=0x200 (same index 0 with BTB_IDX_BITS=6, different tag) target 0x300 → lookup 0x100 misses (lkp_taken=0), 0x200 hits.
- Same-cycle collision: lookup idx equal to upd_pht_idx while upd_valid → lookup reflects old counter; next cycle reflects new.
- Stats: 10 updates with 3 upd_mispred, plus 2 cycles upd_mispred=1, upd_valid=0 → stat_branches=10, stat_mispreds=3; async reset mid-stream clears both to 0.
